// File: rtl/somador_pipeline.sv
// Pipelined ripple adder/subtractor: each stage adds one WIDTH/STAGES-bit segment,
// with operand skew registers, one valid bit per stage and a global stall.
module somador_pipeline #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high. The pipeline moves as one unit (adv); when the output is
  // occupied and not taken, every stage holds and in_ready drops.
  logic adv;

  // Stage registers: operands (B already inverted for subtraction), partial
  // sum with segments 0..k filled in, carry out of segment k, valid bit.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic             ovf_q;
  logic             zero_q;

  // Stage inputs and combinational results
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic [SEG:0]     seg  [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             msb_carry_in;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_comb begin
    a_in[0] = A;
    b_in[0] = sub ? ~B : B;
    s_in[0] = '0;
    c_in[0] = sub ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg[k]  = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, c_in[k]};
      s_nx[k] = s_in[k];
      s_nx[k][k*SEG +: SEG] = seg[k][SEG-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c
    msb_carry_in = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= seg[k][SEG];
      end
      ovf_q  <= msb_carry_in ^ seg[LAST][SEG];
      zero_q <= (s_nx[LAST] == '0);
    end
  end

  assign out_valid = vld_q[LAST];
  assign S         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_somador_pipeline.sv
// Directed bench for somador_pipeline (WIDTH=32, STAGES=4): latency, flags,
// streaming, backpressure and mid-flight reset against hand-computed results.
module tb_somador_pipeline;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        cout;
  logic        ovf;
  logic        zero;

  somador_pipeline #(.WIDTH(32), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Vector table; expected value packed as {S, cout, ovf, zero}
  logic [31:0] va [10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h0000FFFF, 32'h5,
                           32'h1, 32'h7, 32'h80000000, 32'h12345678, 32'h80000000};
  logic [31:0] vb [10] = '{32'h1, 32'h1, 32'h7, 32'h1, 32'h7,
                           32'h2, 32'h7, 32'h1, 32'h9ABCDEF0, 32'h80000000};
  logic        vs [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [34:0] vexp [10] = '{
    {32'h00000000, 3'b101}, {32'h80000000, 3'b010}, {32'hFFFFFFFE, 3'b000},
    {32'h00010000, 3'b000}, {32'hFFFFFFFE, 3'b000}, {32'h00000004, 3'b000},
    {32'h00000000, 3'b101}, {32'h7FFFFFFF, 3'b110}, {32'hACF13568, 3'b000},
    {32'h00000000, 3'b111}};

  // Scoreboard
  logic [34:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int first_out_cyc = -1;
  int last_out_cyc = -1;
  int acc_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, then sample what will
  // transfer on the next edge.
  task automatic cycle(input logic rst, input logic iv, input int idx, input logic ordy);
    logic [34:0] got;
    @(posedge clock);
    #1;
    cyc++;
    reset     = rst;
    in_valid  = iv;
    A         = va[idx];
    B         = vb[idx];
    sub       = vs[idx];
    cin       = vc[idx];
    out_ready = ordy;
    #1;
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (n_out == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
      got = {S, cout, ovf, zero};
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result: got %h expected none", got);
      end
      if (exp_q.size() > 0) chk("result", 64'(got), 64'(exp_q.pop_front()));
    end
    if (!reset && in_valid && in_ready) begin
      exp_q.push_back(vexp[idx]);
      acc_cyc = cyc;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 1'b0, 0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic single(input int idx);
    int t0;
    n_out = 0;
    first_out_cyc = -1;
    cycle(1'b0, 1'b1, idx, 1'b1);
    t0 = acc_cyc;
    for (int i = 0; i < 12 && n_out == 0; i++) cycle(1'b0, 1'b0, 0, 1'b1);
    chk("latency", first_out_cyc - t0, 4);
  endtask

  // Directed sequence
  initial begin
    int t_first;
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b0;
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);

    // Post-reset state, out_ready low to show in_ready follows !out_valid
    cycle(1'b0, 1'b0, 0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single operations: wrap to zero, signed overflow, subtract, segment carry, cin
    single(0);
    single(1);
    single(2);
    single(3);
    single(5);

    // Streaming: 8 back-to-back, results on 8 consecutive cycles
    n_out = 0;
    first_out_cyc = -1;
    cycle(1'b0, 1'b1, 0, 1'b1);
    t_first = acc_cyc;
    for (int i = 1; i < 8; i++) cycle(1'b0, 1'b1, i, 1'b1);
    drain();
    chk("stream_count", n_out, 8);
    chk("stream_latency", first_out_cyc - t_first, 4);
    chk("stream_consecutive", last_out_cyc - first_out_cyc, 7);

    // Backpressure with a full pipeline
    n_out = 0;
    cycle(1'b0, 1'b1, 8, 1'b1);
    cycle(1'b0, 1'b1, 9, 1'b1);
    cycle(1'b0, 1'b1, 6, 1'b1);
    cycle(1'b0, 1'b1, 7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 0, 1'b0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_S_held", S, 32'hACF13568);
    end
    cycle(1'b0, 1'b1, 0, 1'b1);
    cycle(1'b0, 1'b1, 1, 1'b1);
    drain();
    chk("bp_count", n_out, 6);

    // Reset with 3 operations in flight; input offered during reset is dropped
    n_out = 0;
    cycle(1'b0, 1'b1, 0, 1'b1);
    cycle(1'b0, 1'b1, 1, 1'b1);
    cycle(1'b0, 1'b1, 2, 1'b1);
    cycle(1'b1, 1'b1, 3, 1'b1);
    exp_q.delete();
    cycle(1'b0, 1'b0, 0, 1'b1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_S", S, 0);
    chk("midrst_flags", {cout, ovf, zero}, 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, 1'b1);
    chk("midrst_no_results", n_out, 0);
    single(3);
    single(9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/somador_pipeline.md
SOMADOR_PIPELINE -- requirements
Module: somador_pipeline

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be a multiple of STAGES and at least 4.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL be between 1 and WIDTH/4; each stage adds one WIDTH/STAGES-bit segment.
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset, sampled on the rising clock edge.
REQ-005 Port in_valid, input, 1, operands on A, B, sub and cin are valid.
REQ-006 Port in_ready, output, 1, the block accepts operands this cycle.
REQ-007 Port A, input, WIDTH, first operand.
REQ-008 Port B, input, WIDTH, second operand.
REQ-009 Port sub, input, 1: 0 selects S = A + B + cin; 1 selects S = A - B, computed as A + ~B + 1, with cin ignored.
REQ-010 Port cin, input, 1, carry-in used only when sub = 0.
REQ-011 Port out_valid, output, 1, result outputs hold a valid result.
REQ-012 Port out_ready, input, 1, the consumer accepts the result this cycle.
REQ-013 Port S, output, WIDTH, sum or difference modulo 2^WIDTH.
REQ-014 Port cout, output, 1, carry out of bit WIDTH-1; for subtraction, 1 means no borrow.
REQ-015 Port ovf, output, 1, two's-complement signed overflow.
REQ-016 Port zero, output, 1, asserted when S == 0.

Function
REQ-017 An input transfer SHALL occur on a cycle when in_valid && in_ready; an output transfer SHALL occur on a cycle when out_valid && out_ready.
REQ-018 Global advance enable SHALL be adv = out_ready || !out_valid, and in_ready SHALL equal adv combinationally.
REQ-019 When adv = 0, every pipeline register, including valid bits, SHALL hold its value.
REQ-020 Stage k (0..STAGES-1) SHALL add segment k of A and of B-or-~B plus the carry registered by stage k-1; stage 0 SHALL use cin (add) or 1 (sub) as its carry-in.
REQ-021 Segments not yet summed, and already-summed segments, SHALL travel through the pipeline with their operation in skew registers.
REQ-022 Each stage SHALL carry one valid bit; a bubble (no input transfer while adv = 1) SHALL propagate as valid = 0.
REQ-023 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when out_ready is held at 1.
REQ-024 Throughput SHALL be one operation per cycle when out_ready = 1.
REQ-025 Bubbles SHALL NOT be compressed; a stall freezes the whole pipeline.
REQ-026 ovf SHALL be computed as carry-into-MSB XOR carry-out-of-MSB.
REQ-027 zero SHALL be computed from the final registered S.
REQ-028 All result outputs (S, cout, ovf, zero) SHALL be registered outputs of the last stage.
REQ-029 Result outputs SHALL remain stable while out_valid && !out_ready.
REQ-030 Results SHALL leave in input-transfer order; no operation SHALL be dropped or duplicated.
REQ-031 When STAGES = 1, the block SHALL reduce to a single registered WIDTH-bit adder with latency 1.

Reset
REQ-032 While reset = 1 at a rising edge, all stage valid bits SHALL clear, making out_valid = 0 on the next cycle.
REQ-033 While reset = 1 at a rising edge, S, cout, ovf and zero SHALL clear to 0.
REQ-034 Reset SHALL override adv and any input transfer in the same cycle.
REQ-035 Reset mid-operation SHALL discard all in-flight operations.
REQ-036 in_ready SHALL be 1 in the first cycle after reset is released, since out_valid = 0.

Verification (WIDTH=32, STAGES=4)
REQ-037 Add: A=0xFFFFFFFF, B=1, cin=0, sub=0 -> 4 cycles later: S=0, cout=1, ovf=0, zero=1.
REQ-038 Signed overflow: A=0x7FFFFFFF, B=1, sub=0 -> S=0x80000000, ovf=1, cout=0; subtract: A=5, B=7, sub=1 -> S=0xFFFFFFFE, cout=0, ovf=0.
REQ-039 Streaming: 8 back-to-back operations with out_ready=1 -> 8 results on 8 consecutive cycles, starting 4 cycles after the first input, in order.
REQ-040 Backpressure: out_ready=0 for 3 cycles while the pipeline is full -> in_ready=0 for those cycles, S held stable, no loss; after release, results resume in order.
REQ-041 Carry across segment boundary: A=0x0000FFFF, B=0x00000001 -> S=0x00010000; the carry chain crosses stage 1 into stage 2 correctly.
REQ-042 Reset with 3 operations in flight -> out_valid=0 on the next cycle and none of the 3 results ever appears; a new operation afterward completes with latency 4.
